pc_predict_unit: RTL and testbench
==================================

PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 Parameter XLEN, 32, datapath and PC width in bits.
REQ-002 Parameter ADDR_BITS, 10, width of instruction-memory word address.
REQ-003 Parameter BTB_ENTRIES, 16, branch target buffer depth, power of two, minimum 2.
REQ-004 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-005 Parameter EXC_VECTOR, 32'h0000_0800, PC value loaded on exception.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  PC advance enable; low = fetch stall.
REQ-009 exc_req  in  1  exception redirect request.
REQ-010 res_valid  in  1  EX-stage control-transfer resolution valid.
REQ-011 res_pc  in  XLEN  PC of resolved instruction.
REQ-012 res_taken  in  1  actual outcome (jumps always 1).
REQ-013 res_target  in  XLEN  actual target when taken.
REQ-014 res_pred_taken  in  1  prediction carried down pipeline with the instruction.
REQ-015 res_pred_target  in  XLEN  predicted target carried with the instruction.
REQ-016 pc_out  out  XLEN  current fetch PC.
REQ-017 normal_pc  out  XLEN  pc_out + 4.
REQ-018 addr  out  ADDR_BITS  pc_out[ADDR_BITS+1:2].
REQ-019 pred_taken  out  1  prediction for pc_out.
REQ-020 pred_target  out  XLEN  predicted target for pc_out (valid when pred_taken).
REQ-021 flush  out  1  mispredict/exception, kill younger instructions.
REQ-022 mispredict_cnt  out  32  saturating count of mispredictions.

Function
REQ-023 BTB entry: valid bit, tag = PC[XLEN-1:IDX+2], target XLEN bits, 2-bit counter; index IDX = log2(BTB_ENTRIES) bits from PC[IDX+1:2].
REQ-024 Lookup combinational on pc_out: hit = valid && tag match; pred_taken = hit && counter >= 2; pred_target = entry target (0 on miss).
REQ-025 mispredict = res_valid && (res_pred_taken != res_taken || (res_taken && res_pred_target != res_target)).
REQ-026 flush = exc_req || mispredict, combinational, same cycle.
REQ-027 Next-PC priority: rst -> RESET_PC; exc_req -> EXC_VECTOR; mispredict -> res_taken ? res_target : res_pc + 4; !enable -> hold; pred_taken -> pred_target; else normal_pc.
REQ-028 exc_req and mispredict SHALL load the PC even when enable is low.
REQ-029 PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-030 On res_valid with tag hit at res_pc index: counter +1 if taken, -1 if not, saturating at 3 and 0; target rewritten to res_target when taken.
REQ-031 On res_valid with miss and res_taken: allocate/overwrite entry, valid=1, tag/target from res, counter=2.
REQ-032 On res_valid with miss and not taken: no BTB write.
REQ-033 BTB update takes effect next cycle; same-cycle lookup of the written index returns old contents (no bypass).
REQ-034 BTB updates occur regardless of enable; suppressed when exc_req is high.
REQ-035 mispredict_cnt increments by 1 per mispredict cycle, holds at 32'hFFFF_FFFF.
REQ-036 Latency: redirect PC visible on pc_out one cycle after the flush cycle.

Reset
REQ-037 On rst at clock edge: pc_out = RESET_PC, all BTB valid bits and counters = 0, mispredict_cnt = 0, regardless of other inputs.
REQ-038 During rst cycle flush follows REQ-026 combinationally; no BTB or counter update occurs.
REQ-039 Reset mid-operation discards all prediction history; first post-reset lookup misses.

Verification
REQ-040 Reset, enable=1, no resolves, 4 cycles -> pc_out 0,4,8,12; pred_taken=0; flush=0.
REQ-041 res_valid, res_pc=0x40, res_taken=1, res_target=0x100, res_pred_taken=0 -> flush=1, next pc_out=0x100, mispredict_cnt=1; later fetch at 0x40 -> pred_taken=1, pred_target=0x100, next pc 0x100.
REQ-042 Same branch resolved not-taken twice (predicted taken) -> counter 2->1->0, each flush with redirect to 0x44; fetch at 0x40 then pred_taken=0.
REQ-043 enable=0 with mispredict to 0x200 -> pc_out=0x200 next cycle; enable=0 alone -> pc_out holds.
REQ-044 exc_req and mispredict same cycle -> pc_out=EXC_VECTOR, no BTB update, flush=1.
REQ-045 Two branches 0x40 and 0x80 aliasing one index (BTB_ENTRIES=16), both taken -> second overwrites; fetch at 0x40 misses (tag mismatch).

Source files
------------

// File: rtl/pc_predict_if.sv
// Fetch-side bundle of the PC predictor: redirect controls, EX-stage resolutions in,
// fetch PC and prediction out. The master drives requests; the predictor is the slave.
interface pc_predict_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 10
);
    logic                 enable;
    logic                 exc_req;
    logic                 res_valid;
    logic [XLEN-1:0]      res_pc;
    logic                 res_taken;
    logic [XLEN-1:0]      res_target;
    logic                 res_pred_taken;
    logic [XLEN-1:0]      res_pred_target;
    logic [XLEN-1:0]      pc_out;
    logic [XLEN-1:0]      normal_pc;
    logic [ADDR_BITS-1:0] addr;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic                 flush;
    logic [31:0]          mispredict_cnt;

    modport master (
        output enable, exc_req, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pc_out, normal_pc, addr, pred_taken, pred_target, flush, mispredict_cnt
    );

    modport slave (
        input  enable, exc_req, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pc_out, normal_pc, addr, pred_taken, pred_target, flush, mispredict_cnt
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB and 2-bit counters; EX-stage resolutions
// train the BTB and redirect the PC on misprediction or exception.
module pc_predict_unit #(
    parameter int              XLEN        = 32,
    parameter int              ADDR_BITS   = 10,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] EXC_VECTOR  = XLEN'(32'h0000_0800)
) (
    input logic          clk_i,
    input logic          rst_i,
    pc_predict_if.slave  bus
);
    localparam int              IDX     = $clog2(BTB_ENTRIES);
    localparam int              TAG_W   = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [31:0]      mcnt_q;
    logic [31:0]      mcnt_d;

    logic             btb_valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_tgt_q   [BTB_ENTRIES];
    logic [1:0]       btb_ctr_q   [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx_s;
    logic             look_hit_s;
    logic             pred_taken_s;
    logic [XLEN-1:0]  pred_target_s;
    logic [XLEN-1:0]  normal_pc_s;
    logic [IDX-1:0]   res_idx_s;
    logic             res_hit_s;
    logic             mispredict_s;
    logic             btb_upd_s;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Combinational BTB lookup for the current fetch PC and for the resolving PC.
    always_comb begin
        look_idx_s    = pc_q[IDX+1:2];
        look_hit_s    = btb_valid_q[look_idx_s] && (btb_tag_q[look_idx_s] == pc_q[XLEN-1:IDX+2]);
        pred_taken_s  = look_hit_s && btb_ctr_q[look_idx_s][1];
        pred_target_s = look_hit_s ? btb_tgt_q[look_idx_s] : {XLEN{1'b0}};
        normal_pc_s   = pc_q + PC_STEP;
        res_idx_s     = bus.res_pc[IDX+1:2];
        res_hit_s     = btb_valid_q[res_idx_s] && (btb_tag_q[res_idx_s] == bus.res_pc[XLEN-1:IDX+2]);
        mispredict_s  = bus.res_valid &&
                        ((bus.res_pred_taken != bus.res_taken) ||
                         (bus.res_taken && (bus.res_pred_target != bus.res_target)));
        btb_upd_s     = bus.res_valid && !bus.exc_req;
    end

    // Next-PC priority: exception, mispredict repair, stall, prediction, sequential.
    always_comb begin
        pc_d = normal_pc_s;
        if (bus.exc_req) begin
            pc_d = EXC_VECTOR;
        end else if (mispredict_s) begin
            pc_d = bus.res_taken ? bus.res_target : (bus.res_pc + PC_STEP);
        end else if (!bus.enable) begin
            pc_d = pc_q;
        end else if (pred_taken_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = normal_pc_s;
        end
    end

    // Saturating mispredict counter next state.
    always_comb begin
        mcnt_d = mcnt_q;
        if (mispredict_s && (mcnt_q != 32'hFFFF_FFFF)) begin
            mcnt_d = mcnt_q + 32'd1;
        end else begin
            mcnt_d = mcnt_q;
        end
    end

    // PC and mispredict counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            mcnt_q <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            mcnt_q <= mcnt_d;
        end
    end

    // BTB training; hits adjust the counter, taken misses allocate at weakly-taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= {TAG_W{1'b0}};
                btb_tgt_q[i]   <= {XLEN{1'b0}};
                btb_ctr_q[i]   <= 2'd0;
            end
        end else if (btb_upd_s) begin
            if (res_hit_s) begin
                btb_ctr_q[res_idx_s] <= ctr_step(btb_ctr_q[res_idx_s], bus.res_taken);
                if (bus.res_taken) begin
                    btb_tgt_q[res_idx_s] <= bus.res_target;
                end
            end else if (bus.res_taken) begin
                btb_valid_q[res_idx_s] <= 1'b1;
                btb_tag_q[res_idx_s]   <= bus.res_pc[XLEN-1:IDX+2];
                btb_tgt_q[res_idx_s]   <= bus.res_target;
                btb_ctr_q[res_idx_s]   <= 2'd2;
            end
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.normal_pc      = normal_pc_s;
    assign bus.addr           = pc_q[ADDR_BITS+1:2];
    assign bus.pred_taken     = pred_taken_s;
    assign bus.pred_target    = pred_target_s;
    assign bus.flush          = bus.exc_req || mispredict_s;
    assign bus.mispredict_cnt = mcnt_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: a BTB model keyed by (pc/4)%16 and pc/64 is
// compared every cycle, with hand-computed literal checks pinning key points.
module tb_pc_predict_unit;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pc_predict_if #(.XLEN(32), .ADDR_BITS(10)) bus ();

    pc_predict_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit          m_ready = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_valid [16];
    logic [31:0] m_key   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_key[slot(pc)] == pc / 32'd64);
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot(pc)] : 32'd0;
    endfunction

    function automatic bit m_mispredict();
        return bus.res_valid && ((bus.res_pred_taken != bus.res_taken) ||
               (bus.res_taken && (bus.res_pred_target != bus.res_target)));
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        bit mp;
        int s;
        if (rst) begin
            m_pc  = 32'd0;
            m_cnt = 32'd0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 0;
            end
        end else begin
            mp = m_mispredict();
            if (bus.exc_req)            m_pc = 32'h0000_0800;
            else if (mp)                m_pc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
            else if (!bus.enable)       m_pc = m_pc;
            else if (m_pred_taken(m_pc)) m_pc = m_pred_target(m_pc);
            else                        m_pc = m_pc + 32'd4;
            if (mp && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (bus.res_valid && !bus.exc_req) begin
                s = slot(bus.res_pc);
                if (m_hit(bus.res_pc)) begin
                    if (bus.res_taken) begin
                        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = bus.res_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (bus.res_taken) begin
                    m_valid[s] = 1'b1;
                    m_key[s]   = bus.res_pc / 32'd64;
                    m_tgt[s]   = bus.res_target;
                    m_ctr[s]   = 2;
                end
            end
        end
        m_ready = 1'b1;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            check("m_pc_out", bus.pc_out, m_pc);
            check("m_normal_pc", bus.normal_pc, m_pc + 32'd4);
            check("m_addr", {22'd0, bus.addr}, (m_pc / 32'd4) % 32'd1024);
            check("m_pred_taken", {31'd0, bus.pred_taken}, {31'd0, m_pred_taken(m_pc)});
            check("m_pred_target", bus.pred_target, m_pred_target(m_pc));
            check("m_flush", {31'd0, bus.flush}, {31'd0, bus.exc_req | m_mispredict()});
            check("m_cnt", bus.mispredict_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.enable          = 1'b1;
        bus.exc_req         = 1'b0;
        bus.res_valid       = 1'b0;
        bus.res_pc          = 32'd0;
        bus.res_taken       = 1'b0;
        bus.res_target      = 32'd0;
        bus.res_pred_taken  = 1'b0;
        bus.res_pred_target = 32'd0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bus.res_valid       = 1'b1;
        bus.res_pc          = pc;
        bus.res_taken       = tk;
        bus.res_target      = tgt;
        bus.res_pred_taken  = ptk;
        bus.res_pred_target = ptgt;
    endtask

    // Redirect fetch to a PC by resolving the preceding word as a wrongly-predicted fall-through.
    task automatic goto(input logic [31:0] target);
        resolve(target - 32'd4, 1'b0, 32'd0, 1'b1, 32'd0);
        tick();
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_pc", bus.pc_out, 32'h0);
        check("reset_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("reset_flush", {31'd0, bus.flush}, 32'd0);
        check("reset_cnt", bus.mispredict_cnt, 32'd0);
        tick(); check("seq_pc4", bus.pc_out, 32'h4);
        tick(); check("seq_pc8", bus.pc_out, 32'h8);
        tick(); check("seq_pc12", bus.pc_out, 32'hC);

        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        #1 check("mp_flush", {31'd0, bus.flush}, 32'd1);
        tick(); set_idle();
        check("mp_redirect", bus.pc_out, 32'h100);
        check("mp_cnt1", bus.mispredict_cnt, 32'd1);
        goto(32'h40);
        check("learned_taken", {31'd0, bus.pred_taken}, 32'd1);
        check("learned_target", bus.pred_target, 32'h100);
        tick(); check("pred_follow", bus.pc_out, 32'h100);

        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        #1 check("nt_flush1", {31'd0, bus.flush}, 32'd1);
        tick(); check("nt_redirect1", bus.pc_out, 32'h44);
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        tick(); set_idle();
        check("nt_redirect2", bus.pc_out, 32'h44);
        check("nt_cnt", bus.mispredict_cnt, 32'd4);
        goto(32'h40);
        check("ctr_zero_nt", {31'd0, bus.pred_taken}, 32'd0);
        tick(); check("ctr_zero_seq", bus.pc_out, 32'h44);

        bus.enable = 1'b0;
        resolve(32'h50, 1'b1, 32'h200, 1'b0, 32'h0);
        tick(); set_idle(); bus.enable = 1'b0;
        check("stall_mp_redirect", bus.pc_out, 32'h200);
        tick(); tick();
        check("stall_hold", bus.pc_out, 32'h200);
        bus.enable = 1'b1;

        bus.exc_req = 1'b1;
        resolve(32'h60, 1'b1, 32'h300, 1'b0, 32'h0);
        #1 check("exc_flush", {31'd0, bus.flush}, 32'd1);
        tick(); set_idle();
        check("exc_vector", bus.pc_out, 32'h800);
        check("exc_cnt", bus.mispredict_cnt, 32'd7);
        goto(32'h60);
        check("exc_no_alloc", {31'd0, bus.pred_taken}, 32'd0);
        check("exc_no_alloc_tgt", bus.pred_target, 32'h0);

        resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        tick();
        resolve(32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
        tick(); set_idle();
        check("alias_redirect", bus.pc_out, 32'h180);
        goto(32'h40);
        check("alias_miss", {31'd0, bus.pred_taken}, 32'd0);
        check("alias_miss_tgt", bus.pred_target, 32'h0);
        goto(32'h80);
        check("alias_new_tgt", bus.pred_target, 32'h180);
        tick(); check("alias_follow", bus.pc_out, 32'h180);

        goto(32'hFFFF_FFFC);
        check("wrap_normal", bus.normal_pc, 32'h0);
        tick(); check("wrap_pc", bus.pc_out, 32'h0);

        goto(32'hC0);
        resolve(32'hC0, 1'b1, 32'h400, 1'b1, 32'h400);
        #1 check("no_bypass", {31'd0, bus.pred_taken}, 32'd0);
        tick(); set_idle();
        check("no_bypass_seq", bus.pc_out, 32'hC4);

        rst = 1'b1;
        resolve(32'h90, 1'b1, 32'h500, 1'b0, 32'h0);
        #1 check("rst_flush", {31'd0, bus.flush}, 32'd1);
        tick(); rst = 1'b0; set_idle();
        check("rst_mid_pc", bus.pc_out, 32'h0);
        check("rst_mid_cnt", bus.mispredict_cnt, 32'd0);
        goto(32'hC0);
        check("rst_history_gone", {31'd0, bus.pred_taken}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            resolve(32'h80, 1'b1, 32'h180, 1'b1, 32'h180);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            resolve(32'h80, 1'b0, 32'h0, 1'b1, 32'h180);
            tick();
        end
        set_idle();
        goto(32'h80);
        check("ctr_sat_nt", {31'd0, bus.pred_taken}, 32'd0);
        check("ctr_sat_tgt", bus.pred_target, 32'h180);
        check("ctr_sat_cnt", bus.mispredict_cnt, 32'd4);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
